// File: rtl/platform_collision.sv
// Per-frame scan of the platform table: finds the lowest-index active platform the falling
// doodle lands on, pulses collision for one cycle and holds the hit index and scroll request.
module platform_collision #(
    parameter int FPS         = 60,
    parameter int CLK         = 50_000_000,
    parameter int N_PLATFORMS = 90,
    parameter int PLATFORM_W  = 100,
    parameter int DOODLE_W    = 80,
    parameter int DOODLE_H    = 80,
    parameter int FOOT_TOL    = 12,
    parameter int SCROLL_LINE = 300
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [$clog2(CLK/FPS):0]                fps_counter,
    input  logic signed [N_PLATFORMS-1:0][1:0][10:0] platforms,
    input  logic [N_PLATFORMS-1:0]                  platform_activation,
    input  logic [10:0]                             doodle_x,
    input  logic [9:0]                              doodle_y,
    input  logic                                    falling,
    output logic                                    collision,
    output logic [6:0]                              hit_index,
    output logic                                    move_collision,
    output logic                                    busy
);

    localparam logic signed [11:0] DoodleW = 12'(DOODLE_W);
    localparam logic signed [11:0] DoodleH = 12'(DOODLE_H);
    localparam logic signed [11:0] PlatW   = 12'(PLATFORM_W);
    localparam logic signed [11:0] FootTol = 12'(FOOT_TOL);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q;
    logic [6:0]  idx_q;
    logic [6:0]  rec_idx_q;
    logic        found_q;
    logic [10:0] dx_snap_q;
    logic [9:0]  dy_snap_q;
    logic        fall_snap_q;
    logic        collision_q;
    logic [6:0]  hit_index_q;
    logic        move_q;
    logic        busy_q;

    logic              tick;
    logic              hit;
    logic              last;
    logic              found_any;
    logic [6:0]        final_idx;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [11:0] px;
    logic signed [11:0] py;
    logic signed [11:0] foot;

    assign tick = &fps_counter;

    // Doodle coordinates are unsigned screen values; platform coordinates may be negative.
    assign dx   = $signed({1'b0, dx_snap_q});
    assign dy   = $signed({2'b00, dy_snap_q});
    assign py   = $signed({platforms[idx_q][0][10], platforms[idx_q][0]});
    assign px   = $signed({platforms[idx_q][1][10], platforms[idx_q][1]});
    assign foot = dy + DoodleH;

    assign hit = platform_activation[idx_q] && fall_snap_q
              && (py <= foot) && (foot <= py + FootTol - 12'sd1)
              && (dx + DoodleW - 12'sd1 >= px) && (dx <= px + PlatW - 12'sd1);

    assign last      = (idx_q == 7'(N_PLATFORMS - 1));
    assign found_any = found_q | hit;
    assign final_idx = found_q ? rec_idx_q : idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rec_idx_q   <= '0;
            found_q     <= 1'b0;
            dx_snap_q   <= '0;
            dy_snap_q   <= '0;
            fall_snap_q <= 1'b0;
            collision_q <= 1'b0;
            hit_index_q <= '0;
            move_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            collision_q <= 1'b0;
            // A tick in any state (re)starts the scan; an aborted scan never reaches DONE.
            if (tick) begin
                dx_snap_q   <= doodle_x;
                dy_snap_q   <= doodle_y;
                fall_snap_q <= falling;
                found_q     <= 1'b0;
                idx_q       <= '0;
                busy_q      <= 1'b1;
                state_q     <= StScan;
            end else begin
                case (state_q)
                    StScan: begin
                        if (hit && !found_q) begin
                            found_q   <= 1'b1;
                            rec_idx_q <= idx_q;
                        end
                        if (last) begin
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            collision_q <= found_any;
                            if (found_any) begin
                                hit_index_q <= final_idx;
                                move_q      <= ({1'b0, dy_snap_q} < 11'(SCROLL_LINE));
                            end else begin
                                move_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + 7'd1;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign collision      = collision_q;
    assign hit_index      = hit_index_q;
    assign move_collision = move_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_platform_collision.sv
// Bench for platform_collision: directed landing/edge/restart/reset scenarios plus random
// frames checked against a lowest-index-hit model of the landing rules.
module tb_platform_collision;

    localparam int NP = 90;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [20:0]                   fps_counter = '0;
    logic signed [NP-1:0][1:0][10:0] platforms = '0;
    logic [NP-1:0]                 platform_activation = '0;
    logic [10:0]                   doodle_x = '0;
    logic [9:0]                    doodle_y = '0;
    logic                          falling = 1'b0;
    logic                          collision;
    logic [6:0]                    hit_index;
    logic                          move_collision;
    logic                          busy;

    int total = 0;
    int bad   = 0;

    int px [NP];
    int py [NP];
    bit act [NP];

    int exp_hit  = 0;
    bit exp_move = 1'b0;

    platform_collision dut (
        .clk                 (clk),
        .rst                 (rst),
        .fps_counter         (fps_counter),
        .platforms           (platforms),
        .platform_activation (platform_activation),
        .doodle_x            (doodle_x),
        .doodle_y            (doodle_y),
        .falling             (falling),
        .collision           (collision),
        .hit_index           (hit_index),
        .move_collision      (move_collision),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plats();
        for (int i = 0; i < NP; i++) begin
            px[i] = 0;
            py[i] = 0;
            act[i] = 1'b0;
        end
    endtask

    task automatic apply_plats();
        for (int i = 0; i < NP; i++) begin
            platforms[i][0] = 11'(py[i]);
            platforms[i][1] = 11'(px[i]);
            platform_activation[i] = act[i];
        end
    endtask

    task automatic set_doodle(input int x, input int y, input bit f);
        doodle_x = 11'(x);
        doodle_y = 10'(y);
        falling  = f;
    endtask

    // Landing rules straight from the geometry: first active platform whose top band holds the feet.
    function automatic void model(output bit f, output int idx);
        int dx, dy, foot;
        dx = int'(doodle_x);
        dy = int'(doodle_y);
        foot = dy + 80;
        f = 1'b0;
        idx = 0;
        for (int i = 0; i < NP; i++) begin
            if (!f && act[i] && falling && py[i] <= foot && foot <= py[i] + 11
                && dx + 79 >= px[i] && dx <= px[i] + 99) begin
                f = 1'b1;
                idx = i;
            end
        end
    endfunction

    // Tick in the current cycle (T), then check busy/collision through T+92.
    task automatic run_frame(input string name, input bit ef, input int ei);
        bit em;
        em = ef && (int'(doodle_y) < 300);
        apply_plats();
        fps_counter = '1;
        step();
        fps_counter = '0;
        for (int c = 1; c <= NP; c++) begin
            total++;
            if (busy !== 1'b1 || collision !== 1'b0) begin
                bad++;
                $display("FAIL %s scan T+%0d: busy=%b collision=%b, required busy=1 collision=0",
                         name, c, busy, collision);
            end
            step();
        end
        if (ef) exp_hit = ei;
        exp_move = em;
        total++;
        if (collision !== ef || busy !== 1'b0 || hit_index !== 7'(exp_hit)
            || move_collision !== exp_move) begin
            bad++;
            $display("FAIL %s done: coll=%b busy=%b idx=%0d move=%b, required %b 0 %0d %b",
                     name, collision, busy, hit_index, move_collision, ef, exp_hit, exp_move);
        end
        step();
        total++;
        if (collision !== 1'b0 || hit_index !== 7'(exp_hit) || move_collision !== exp_move) begin
            bad++;
            $display("FAIL %s after done: coll=%b idx=%0d move=%b, required 0 %0d %b",
                     name, collision, hit_index, move_collision, exp_hit, exp_move);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        total++;
        if (collision !== 1'b0 || hit_index !== 7'd0 || move_collision !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: coll=%b idx=%0d move=%b busy=%b, required all 0",
                     collision, hit_index, move_collision, busy);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        clear_plats();
        act[7] = 1'b1; py[7] = 400; px[7] = 342;
        set_doodle(330, 323, 1'b1);
        run_frame("basic", 1'b1, 7);
    endtask

    task automatic test_scroll();
        clear_plats();
        act[30] = 1'b1; py[30] = 330; px[30] = 342;
        set_doodle(342, 250, 1'b1);
        run_frame("scroll", 1'b1, 30);
        repeat (20) step();
        total++;
        if (move_collision !== 1'b1 || hit_index !== 7'd30) begin
            bad++;
            $display("FAIL scroll hold: move=%b idx=%0d, required 1 30", move_collision, hit_index);
        end
    endtask

    task automatic test_no_land();
        clear_plats();
        act[7] = 1'b1; py[7] = 400; px[7] = 342;
        set_doodle(330, 323, 1'b0);
        run_frame("not_falling", 1'b0, 0);
        act[7] = 1'b0;
        set_doodle(330, 323, 1'b1);
        run_frame("inactive", 1'b0, 0);
    endtask

    task automatic test_priority();
        clear_plats();
        act[5] = 1'b1;  py[5] = 400;  px[5] = 342;
        act[20] = 1'b1; py[20] = 400; px[20] = 300;
        set_doodle(330, 323, 1'b1);
        run_frame("priority", 1'b1, 5);
    endtask

    task automatic test_edges();
        clear_plats();
        act[3] = 1'b1; py[3] = 400; px[3] = 279;
        set_doodle(200, 323, 1'b1);
        run_frame("h_right_hit", 1'b1, 3);
        px[3] = 280;
        run_frame("h_right_miss", 1'b0, 0);
        px[3] = 200;
        set_doodle(299, 323, 1'b1);
        run_frame("h_left_hit", 1'b1, 3);
        set_doodle(300, 323, 1'b1);
        run_frame("h_left_miss", 1'b0, 0);
        clear_plats();
        act[11] = 1'b1; py[11] = 400; px[11] = 342;
        set_doodle(330, 331, 1'b1);
        run_frame("v_bottom_hit", 1'b1, 11);
        set_doodle(330, 332, 1'b1);
        run_frame("v_bottom_miss", 1'b0, 0);
        set_doodle(330, 319, 1'b1);
        run_frame("v_top_miss", 1'b0, 0);
        clear_plats();
        act[40] = 1'b1; py[40] = -162; px[40] = 0;
        set_doodle(0, 0, 1'b1);
        run_frame("neg_y", 1'b0, 0);
        act[41] = 1'b1; py[41] = 400; px[41] = -50;
        set_doodle(0, 320, 1'b1);
        run_frame("neg_x", 1'b1, 41);
        act[12] = 1'b1; py[12] = 150; px[12] = 10;
        set_doodle(0, 70, 1'b1);
        run_frame("neg_x_low_idx_scroll", 1'b1, 12);
    endtask

    task automatic test_restart();
        clear_plats();
        act[7] = 1'b1;  py[7] = 400;  px[7] = 342;
        act[30] = 1'b1; py[30] = 330; px[30] = 342;
        apply_plats();
        set_doodle(330, 323, 1'b1);
        fps_counter = '1;
        step();
        fps_counter = '0;
        repeat (49) step();
        set_doodle(342, 250, 1'b1);
        fps_counter = '1;
        step();
        fps_counter = '0;
        for (int c = 51; c <= 140; c++) begin
            total++;
            if (collision !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL restart T+%0d: coll=%b busy=%b, required 0 1", c, collision, busy);
            end
            step();
        end
        exp_hit = 30;
        exp_move = 1'b1;
        total++;
        if (collision !== 1'b1 || hit_index !== 7'd30 || move_collision !== 1'b1) begin
            bad++;
            $display("FAIL restart done: coll=%b idx=%0d move=%b, required 1 30 1",
                     collision, hit_index, move_collision);
        end
        step();
    endtask

    task automatic test_random();
        bit f;
        int idx;
        for (int n = 0; n < 20; n++) begin
            int dx, dy;
            clear_plats();
            dx = int'($urandom_range(0, 1800));
            dy = int'($urandom_range(0, 900));
            set_doodle(dx, dy, ($urandom % 4) != 0);
            for (int i = 0; i < NP; i++) begin
                act[i] = ($urandom % 3) == 0;
                px[i] = dx + int'($urandom_range(0, 300)) - 200;
                py[i] = dy + 80 + int'($urandom_range(0, 40)) - 20;
                if (px[i] > 1023) px[i] = 1023;
                if (py[i] > 1023) py[i] = 1023;
            end
            model(f, idx);
            run_frame($sformatf("random%0d", n), f, idx);
        end
    endtask

    task automatic test_reset_mid();
        clear_plats();
        act[7] = 1'b1; py[7] = 400; px[7] = 342;
        apply_plats();
        set_doodle(330, 323, 1'b1);
        fps_counter = '1;
        step();
        fps_counter = '0;
        repeat (39) step();
        rst = 1'b0;
        #1;
        exp_hit = 0;
        exp_move = 1'b0;
        total++;
        if (busy !== 1'b0 || collision !== 1'b0 || hit_index !== 7'd0 || move_collision !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b coll=%b idx=%0d move=%b, required all 0",
                     busy, collision, hit_index, move_collision);
        end
        step();
        rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            total++;
            if (collision !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid after %0d: coll=%b busy=%b, required 0 0", c, collision, busy);
            end
            step();
        end
    endtask

    initial begin
        clear_plats();
        test_reset();
        test_basic();
        test_scroll();
        test_no_land();
        test_priority();
        test_edges();
        test_restart();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
